// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state and flag bundle for the sequential ALU.
package alu_pkg;
  localparam logic [2:0] CLS_ARITH = 3'd0;
  localparam logic [2:0] CLS_LOGIC = 3'd1;
  localparam logic [2:0] CLS_SHIFT = 3'd2;
  localparam logic [2:0] CLS_CMP   = 3'd3;
  localparam logic [2:0] CLS_MUL   = 3'd4;

  localparam logic [2:0] F_ADD   = 3'd0;
  localparam logic [2:0] F_SUB   = 3'd1;
  localparam logic [2:0] F_AND   = 3'd0;
  localparam logic [2:0] F_OR    = 3'd1;
  localparam logic [2:0] F_XOR   = 3'd2;
  localparam logic [2:0] F_NOR   = 3'd3;
  localparam logic [2:0] F_NOT   = 3'd4;
  localparam logic [2:0] F_SLL   = 3'd0;
  localparam logic [2:0] F_SRL   = 3'd1;
  localparam logic [2:0] F_SRA   = 3'd2;
  localparam logic [2:0] F_SLT   = 3'd0;
  localparam logic [2:0] F_SLTU  = 3'd1;
  localparam logic [2:0] F_SEQ   = 3'd2;
  localparam logic [2:0] F_MUL   = 3'd0;
  localparam logic [2:0] F_MULHU = 3'd1;

  typedef enum logic {IDLE, MUL} state_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic illegal;
  } flags_t;
endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, WIDTH steps.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int SHW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     cnt;

  // product already includes the current step, so it is final when done is high
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = busy && (cnt == SHW'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      cnt    <= '0;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides; single-cycle ops plus an
// iterative multiplier sequenced by a two-state FSM.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);
  localparam int SHW = $clog2(WIDTH);

  state_t             state;
  logic [2:0]         cls, fn;
  logic               accept, is_mul, mul_hi, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   mul_res, bx, sc_res;
  logic [WIDTH:0]     sum;
  logic [SHW-1:0]     shamt;
  logic               add_ovf;
  flags_t             sc_fl;
  logic               unused_bits;

  assign cls         = opcode[5:3];
  assign fn          = opcode[2:0];
  assign unused_bits = ^{opcode[7:6], mul_busy};
  assign shamt       = b[SHW-1:0];

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (cls == CLS_MUL) && (fn == F_MUL || fn == F_MULHU);

  // SUB reuses the adder as a + ~b + 1
  assign bx      = fn[0] ? ~b : b;
  assign sum     = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, fn[0]};
  assign add_ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    sc_res = '0;
    sc_fl  = '0;
    case (cls)
      CLS_ARITH:
        if (fn == F_ADD || fn == F_SUB) begin
          sc_res         = sum[WIDTH-1:0];
          sc_fl.carry    = sum[WIDTH];
          sc_fl.overflow = add_ovf;
        end else sc_fl.illegal = 1'b1;
      CLS_LOGIC:
        case (fn)
          F_AND:   sc_res = a & b;
          F_OR:    sc_res = a | b;
          F_XOR:   sc_res = a ^ b;
          F_NOR:   sc_res = ~(a | b);
          F_NOT:   sc_res = ~a;
          default: sc_fl.illegal = 1'b1;
        endcase
      CLS_SHIFT:
        case (fn)
          F_SLL:   sc_res = a << shamt;
          F_SRL:   sc_res = a >> shamt;
          F_SRA:   sc_res = $unsigned($signed(a) >>> shamt);
          default: sc_fl.illegal = 1'b1;
        endcase
      CLS_CMP:
        case (fn)
          F_SLT:   sc_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
          F_SLTU:  sc_res = {{(WIDTH-1){1'b0}}, a < b};
          F_SEQ:   sc_res = {{(WIDTH-1){1'b0}}, a == b};
          default: sc_fl.illegal = 1'b1;
        endcase
      default: sc_fl.illegal = 1'b1;
    endcase
    sc_fl.zero = (sc_res == '0);
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign mul_res = mul_hi ? mul_prod[2*WIDTH-1:WIDTH] : mul_prod[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      mul_hi    <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (accept && is_mul) begin
            state     <= MUL;
            mul_hi    <= (fn == F_MULHU);
            out_valid <= 1'b0;
          end else if (accept) begin
            result    <= sc_res;
            zero      <= sc_fl.zero;
            carry     <= sc_fl.carry;
            overflow  <= sc_fl.overflow;
            illegal   <= sc_fl.illegal;
            out_valid <= 1'b1;
          end else if (out_ready) out_valid <= 1'b0;
        MUL:
          if (mul_done) begin
            state     <= IDLE;
            result    <= mul_res;
            zero      <= (mul_res == '0);
            carry     <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq (WIDTH=32): one task per feature.
module tb_alu_seq;
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  opcode;
  logic [31:0] a, b, result;
  logic        zero, carry, overflow, illegal;
  int          tests = 0;
  int          fails = 0;

  localparam logic [7:0] OP_ADD = 8'h00, OP_SUB = 8'h01, OP_AND = 8'h08, OP_OR = 8'h09;
  localparam logic [7:0] OP_XOR = 8'h0A, OP_NOR = 8'h0B, OP_NOT = 8'h0C;
  localparam logic [7:0] OP_SLL = 8'h10, OP_SRL = 8'h11, OP_SRA = 8'h12;
  localparam logic [7:0] OP_SLT = 8'h18, OP_SLTU = 8'h19, OP_SEQ = 8'h1A;
  localparam logic [7:0] OP_MUL = 8'h20, OP_MULHU = 8'h21;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .carry(carry), .overflow(overflow), .illegal(illegal)
  );

  // Drive one op for one edge; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] op, input logic [31:0] aa, input logic [31:0] bb);
    @(negedge clk);
    opcode = op; a = aa; b = bb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid after a mul accept; lat = edges taken (0 on timeout).
  task automatic wait_out(output int lat, output int busy_bad);
    lat = 0; busy_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = k; break; end
      if (in_ready) busy_bad++;
    end
  endtask

  task automatic test_reset();
    bit seen;
    repeat (2) @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL rst_result got=%h exp=0", result); end
    tests++; if ({zero, carry, overflow, illegal} !== 4'b0) begin fails++; $display("FAIL rst_flags got=%b exp=0000", {zero, carry, overflow, illegal}); end
    @(negedge clk); rst_n = 1'b1;
    send(OP_ADD, 32'd5, 32'd6);
    tests++; if (result !== 32'd11) begin fails++; $display("FAIL pre_add result got=%h exp=%h", result, 32'd11); end
    send(OP_MUL, 32'd7, 32'd9);
    repeat (5) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midmul_rst valid got=%b exp=0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midmul_rst in_ready got=%b exp=1", in_ready); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL midmul_rst result got=%h exp=0", result); end
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1; end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL stale_product seen=%b exp=0", seen); end
  endtask

  task automatic test_arith();
    send(OP_ADD, 32'hFFFF_FFFF, 32'h1);
    tests++; if ({result, zero, carry, overflow} !== {32'h0, 3'b110}) begin fails++; $display("FAIL add_wrap got=%h z%b c%b v%b exp=0 z1 c1 v0", result, zero, carry, overflow); end
    send(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    tests++; if ({result, zero, carry, overflow} !== {32'h8000_0000, 3'b001}) begin fails++; $display("FAIL add_ovf got=%h z%b c%b v%b exp=80000000 z0 c0 v1", result, zero, carry, overflow); end
    send(OP_SUB, 32'd3, 32'd5);
    tests++; if ({result, carry, overflow} !== {32'hFFFF_FFFE, 2'b00}) begin fails++; $display("FAIL sub_borrow got=%h c%b v%b exp=fffffffe c0 v0", result, carry, overflow); end
    send(OP_SUB, 32'd5, 32'd3);
    tests++; if ({result, carry} !== {32'd2, 1'b1}) begin fails++; $display("FAIL sub_noborrow got=%h c%b exp=2 c1", result, carry); end
    send(8'hC0, 32'd10, 32'd20);
    tests++; if (result !== 32'd30) begin fails++; $display("FAIL add_hibits got=%h exp=%h", result, 32'd30); end
  endtask

  task automatic test_logic();
    logic [7:0]  ops [5] = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_NOT};
    logic [31:0] exp [5] = '{32'h00F0_000F, 32'hFFF0_0FFF, 32'hFF00_0FF0, 32'h000F_F000, 32'h0F0F_FF00};
    for (int i = 0; i < 5; i++) begin
      send(ops[i], 32'hF0F0_00FF, 32'h0FF0_0F0F);
      tests++; if ({result, carry, overflow} !== {exp[i], 2'b00}) begin fails++; $display("FAIL logic_%0d got=%h c%b v%b exp=%h", i, result, carry, overflow, exp[i]); end
    end
  endtask

  task automatic test_shift_cmp();
    send(OP_SRA, 32'h8000_0000, 32'h21);
    tests++; if (result !== 32'hC000_0000) begin fails++; $display("FAIL sra got=%h exp=c0000000", result); end
    send(OP_SLL, 32'h1, 32'd31);
    tests++; if (result !== 32'h8000_0000) begin fails++; $display("FAIL sll got=%h exp=80000000", result); end
    send(OP_SRL, 32'h8000_0000, 32'd4);
    tests++; if (result !== 32'h0800_0000) begin fails++; $display("FAIL srl got=%h exp=08000000", result); end
    send(OP_SLT, 32'hFFFF_FFFF, 32'h1);
    tests++; if (result !== 32'h1) begin fails++; $display("FAIL slt got=%h exp=1", result); end
    send(OP_SLTU, 32'hFFFF_FFFF, 32'h1);
    tests++; if ({result, zero} !== {32'h0, 1'b1}) begin fails++; $display("FAIL sltu got=%h z%b exp=0 z1", result, zero); end
    send(OP_SEQ, 32'd5, 32'd5);
    tests++; if (result !== 32'h1) begin fails++; $display("FAIL seq got=%h exp=1", result); end
  endtask

  task automatic test_mul();
    logic [7:0]  ops [4] = '{OP_MUL, OP_MULHU, OP_MUL, OP_MULHU};
    logic [31:0] av  [4] = '{32'h1_0000, 32'h1_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    logic [31:0] bv  [4] = '{32'h1_0000, 32'h1_0000, 32'h10, 32'hFFFF_FFFF};
    logic [31:0] exp [4] = '{32'h0, 32'h1, 32'h2345_6780, 32'hFFFF_FFFE};
    int lat, busy_bad;
    for (int i = 0; i < 4; i++) begin
      send(ops[i], av[i], bv[i]);
      tests++; if ({in_ready, out_valid} !== 2'b00) begin fails++; $display("FAIL mul%0d_accept rdy%b vld%b exp 0 0", i, in_ready, out_valid); end
      opcode = OP_ADD; a = 32'hDEAD; b = 32'hBEEF;
      wait_out(lat, busy_bad);
      tests++; if (lat !== 32) begin fails++; $display("FAIL mul%0d_latency got=%0d exp=32", i, lat); end
      tests++; if (busy_bad !== 0) begin fails++; $display("FAIL mul%0d_in_ready high for %0d cycles exp=0", i, busy_bad); end
      tests++; if ({result, zero, carry} !== {exp[i], exp[i] == 32'h0, 1'b0}) begin fails++; $display("FAIL mul%0d got=%h z%b exp=%h", i, result, zero, exp[i]); end
    end
  endtask

  task automatic test_back_to_back();
    repeat (2) @(posedge clk);
    @(negedge clk); out_ready = 1'b0;
    send(OP_ADD, 32'd1, 32'd2);
    tests++; if ({out_valid, result} !== {1'b1, 32'd3}) begin fails++; $display("FAIL bp_add vld%b got=%h exp=3", out_valid, result); end
    opcode = OP_AND; a = 32'hFF; b = 32'h0F; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++; if ({out_valid, in_ready, result} !== {2'b10, 32'd3}) begin fails++; $display("FAIL bp_hold%0d vld%b rdy%b got=%h exp=3", i, out_valid, in_ready, result); end
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    tests++; if ({out_valid, result} !== {1'b1, 32'h0F}) begin fails++; $display("FAIL b2b_and vld%b got=%h exp=0f", out_valid, result); end
    opcode = OP_XOR;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++; if ({out_valid, result} !== {1'b1, 32'hF0}) begin fails++; $display("FAIL b2b_xor vld%b got=%h exp=f0", out_valid, result); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain vld got=%b exp=0", out_valid); end
  endtask

  task automatic test_illegal();
    logic [7:0] ops [3] = '{8'h38, 8'h05, 8'h22};
    for (int i = 0; i < 3; i++) begin
      send(OP_ADD, 32'd1, 32'd1);
      send(ops[i], 32'h55, 32'h66);
      tests++; if ({out_valid, illegal, zero, result} !== {3'b111, 32'h0}) begin fails++; $display("FAIL illegal_%0d vld%b ill%b z%b got=%h exp=0", i, out_valid, illegal, zero, result); end
    end
    send(OP_ADD, 32'd1, 32'd1);
    tests++; if ({illegal, result} !== {1'b0, 32'd2}) begin fails++; $display("FAIL illegal_clear ill%b got=%h exp=2", illegal, result); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = 8'h0; a = '0; b = '0;
    test_reset();
    test_arith();
    test_logic();
    test_shift_cmp();
    test_mul();
    test_back_to_back();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Registered, parametrised-width ALU with a valid/ready handshake on both input and output sides. It provides the single-cycle arithmetic, logic, shift and compare operations, adds an iterative shift-add multiplier, and reports status flags. It sits between the decode/issue stage and writeback, and one operation is in flight at a time. Single-cycle ops sustain a throughput of 1 per clock when the output is not back-pressured.

Parameters:
WIDTH, 32, operand/result width; must be a power of 2 and ≥ 8.
SHW, $clog2(WIDTH), shift-amount and multiply-counter width (derived; not overridable).

Ports:
clk  input  1  clock; all state updates on its rising edge.
rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
in_valid  input  1  opcode/a/b are valid this cycle.
in_ready  output  1  block can accept an operation this cycle.
opcode  input  8  bits [5:3] = unit class, bits [2:0] = func; bits [7:6] are ignored.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B; the shift amount is b[SHW-1:0].
out_valid  output  1  result and flags are valid.
out_ready  input  1  consumer takes the result this cycle.
result  output  WIDTH  operation result.
zero  output  1  result == 0.
carry  output  1  ADD: carry-out. SUB: carry-out of a + ~b + 1 (1 = no borrow). 0 for all other ops.
overflow  output  1  signed overflow for ADD/SUB; 0 otherwise.
illegal  output  1  opcode class/func is undefined; result forced to 0.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; out_valid=0; result=0; zero=0; carry=0; overflow=0; illegal=0. Reset overrides every other event, including an in-flight multiply, which is discarded.
- Accept condition: in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready).
- Class 000, arith: func 000 = ADD, 001 = SUB.
- Class 001, logic: func 000 = AND, 001 = OR, 010 = XOR, 011 = NOR, 100 = NOT a.
- Class 010, shift: func 000 = SLL, 001 = SRL, 010 = SRA, by b[SHW-1:0].
- Class 011, compare: func 000 = SLT (signed), 001 = SLTU, 010 = SEQ. Result is 0 or 1, zero-extended to WIDTH.
- Class 100, mul: func 000 = MUL (low WIDTH bits of the unsigned product), 001 = MULHU (high WIDTH bits).
- Any other class/func combination: result=0, illegal=1, zero=1. Latency is 1, as for a single-cycle op.
- Single-cycle ops: on the accepting edge, the output registers load the result and flags and out_valid goes to 1. Latency is 1 clock.
- State machine, IDLE → MUL: a mul op is accepted. Latch a and b and clear the 2·WIDTH accumulator and the counter. out_valid goes to 0 unless the output handshake also completes on that edge.
- State machine, MUL: one shift-add step per edge; the counter increments.
- State machine, MUL → IDLE: on the edge where counter == WIDTH-1. The selected product half and its flags load into the output registers and out_valid=1. The result is therefore visible WIDTH edges after the accept edge.
- in_ready=0 throughout MUL.
- Output hold: while out_valid && !out_ready, result and all flags stay stable and no new op is accepted.
- Simultaneous events: when out_valid && out_ready && a new op is accepted on the same edge, the new single-cycle result replaces the old one and out_valid stays 1. When out_ready=1 with no new accept, out_valid goes to 0.
- Inputs are sampled only on the accept edge; changes to a, b or opcode during MUL have no effect.
- Width rules: shifts use only the low SHW bits of b. SRA replicates a[WIDTH-1]. No outputs other than result are wider than 1 bit.

Decomposition:
- Shared package alu_pkg holds:
  - class localparams: CLS_ARITH, CLS_LOGIC, CLS_SHIFT, CLS_CMP, CLS_MUL;
  - func localparams per class;
  - the state enum {IDLE, MUL}.
- One sub-module, alu_mul_iter: the iterative shift-add multiplier (start, a, b → busy, done, product[2·WIDTH-1:0]). The top-level FSM sequences it.
- Single-cycle datapath is combinational logic in the top level.

Test Plan:
- Reset: hold rst_n=0 for 2 edges mid-MUL with a=7, b=9 → out_valid=0, in_ready=1, result=0; no stale product appears afterwards.
- ADD/SUB, WIDTH=32:
  - ADD 0xFFFFFFFF+1 → result=0, zero=1, carry=1, overflow=0.
  - ADD 0x7FFFFFFF+1 → result 0x80000000, overflow=1.
  - SUB 3−5 → result 0xFFFFFFFE, carry=0.
- Shift/compare:
  - SRA 0x80000000 by b=0x21 (amount 1) → result 0xC0000000.
  - SLT a=−1, b=1 → result 1.
  - SLTU with the same operands → result 0.
- Multiply:
  - MUL 0x10000 × 0x10000 → result 0, zero=1; out_valid rises 32 edges after accept; in_ready=0 throughout.
  - MULHU with the same operands → result 1.
- Backpressure and throughput:
  - ADD 1+2 with out_ready=0 for 3 cycles → result 3 stays stable and in_ready=0.
  - Then out_ready=1 with a back-to-back AND accepted on the same edge → result updates with no bubble.
- Illegal: opcode class 111 → illegal=1, result=0, zero=1, latency 1; the next legal op clears illegal.
